reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Synchronous reset sequencer for the Matrak SoC. Sits between the board reset and the core/peripheral domains.
//  - Stretches rst_i into NUM_CH reset outputs.
//  - Releases the outputs in a staggered order: ch0 first (bus/memory), last channel last (core).
//  - Supports software-requested re-reset, and an optional watchdog-forced re-reset.
// PARAMETERS
//  NUM_CH       3     number of reset channels, >=1
//  HOLD_CYCLES  16    cycles all channels stay asserted after reset cause ends, >=1
//  GAP_CYCLES   4     cycles between consecutive channel releases, >=0
//  WDT_CYCLES   1024  watchdog timeout in RUN (used only with RST_WDT_EN), >=2
// PORTS
//  clk_i           in   1       single clock
//  rst_i           in   1       synchronous active-high reset
//  soft_rst_req_i  in   1       software re-reset request, level-sampled
//  wdt_kick_i      in   1       watchdog kick pulse
//  rst_o           out  NUM_CH  per-channel reset, active-high
//  ready_o         out  1       all channels released
//  soft_rst_ack_o  out  1       1-cycle pulse: soft request accepted
//  wdt_fired_o     out  1       sticky: watchdog caused a reset
// BEHAVIOUR
//  - All outputs are registered.
//  - rst_i is synchronous and active-high, and has priority over every other input.
//    Edge with rst_i=1 -> state ASSERT, counters=0, rst_o=all 1, ready_o=0, soft_rst_ack_o=0, wdt_fired_o=0.
//  - FSM states: ASSERT -> RELEASE -> RUN; RUN -> ASSERT on soft or watchdog reset.
//    * ASSERT: count edges.
//      Let k=1 be the first edge with rst_i=0, or the edge after a soft/watchdog entry.
//      After edge k=HOLD_CYCLES, rst_o[0] drops and the FSM enters RELEASE.
//    * RELEASE: rst_o[i] drops after edge HOLD_CYCLES+i*GAP_CYCLES.
//      ready_o rises on the edge after the last channel is released; state becomes RUN.
//      Defaults: ch0@16, ch1@20, ch2@24, ready_o@25.
//    * GAP_CYCLES=0: all channels drop together at HOLD_CYCLES; ready_o rises one edge later.
//    * Released channels never re-assert except on entry to ASSERT.
//  - Soft reset:
//    * soft_rst_req_i=1 sampled in RUN -> next edge: ASSERT, rst_o=all 1, ready_o=0, soft_rst_ack_o=1 for one cycle.
//    * Requests in ASSERT/RELEASE are ignored: no ack, no restart.
//    * A request held high keeps re-triggering each time RUN is reached.
//  - rst_i mid-sequence: the sequence restarts from k=1 after rst_i falls.
//  - Counter width: $clog2(HOLD_CYCLES+NUM_CH*GAP_CYCLES+1).
//    The counter must not wrap; it saturates in RUN.
// CONFIGURATION
//  - Macro RST_WDT_EN defined:
//    * In RUN, the watchdog counter increments each cycle.
//    * wdt_kick_i=1 clears it.
//    * Reaching WDT_CYCLES-1 with no kick -> next edge enters ASSERT (as soft reset, but no ack) and sets wdt_fired_o.
//    * wdt_fired_o is cleared only by rst_i.
//    * The counter is cleared and frozen outside RUN.
//    * A kick and a soft request in the same cycle: soft reset wins.
//  - Macro RST_WDT_EN not defined: no watchdog logic; wdt_kick_i is ignored; wdt_fired_o is tied to 0.
// STRUCTURE
//  - Package matrak_rst_pkg holds:
//    * state encoding localparams: ST_ASSERT=2'd0, ST_RELEASE=2'd1, ST_RUN=2'd2;
//    * default HOLD/GAP/WDT constants.
//  - Sub-module rst_wdt: the watchdog counter, instantiated only under RST_WDT_EN.
//  - FSM and channel release logic stay in reset_sequencer.
// TESTING
//  1. Defaults; rst_i high 3 cycles then low -> rst_o=3'b111 through edge 15; 3'b110@16, 3'b100@20, 3'b000@24; ready_o=1@25.
//  2. In RUN, soft_rst_req_i pulse 1 cycle -> next edge: rst_o=3'b111, ack=1 for exactly 1 cycle; sequence repeats (ch0 drop 16 edges later).
//  3. soft_rst_req_i during RELEASE (edge 18) -> no ack; release timing unchanged from scenario 1.
//  4. rst_i pulsed at edge 22 (ch0 already released) -> all rst_o=1 next edge; full sequence restarts from the fall of rst_i.
//  5. GAP_CYCLES=0, NUM_CH=1, HOLD_CYCLES=1 -> rst_o drops after the first edge with rst_i=0; ready_o one edge later.
//  6. RST_WDT_EN, WDT_CYCLES=8, no kicks -> re-reset 8 cycles after RUN; wdt_fired_o=1 until rst_i. Kick every 5 cycles -> no reset.

Source files
------------

// File: rtl/matrak_rst_pkg.sv
// Shared definitions for the Matrak reset sequencer: FSM state encoding and default timing.
package matrak_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 4;
  localparam int DEF_WDT_CYCLES  = 1024;

  // Edge count (k) after which channel ch is released.
  function automatic int release_edge(input int hold, input int gap, input int ch);
    return hold + ch * gap;
  endfunction

endpackage

// File: rtl/rst_wdt.sv
// Watchdog counter for the reset sequencer; only instantiated when RST_WDT_EN is defined.
module rst_wdt
  import matrak_rst_pkg::*;
#(
  parameter int WDT_CYCLES = DEF_WDT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic kick_i,
  input  logic soft_i,
  output logic expire_o
);

  localparam int W = $clog2(WDT_CYCLES);
  localparam logic [W-1:0] LAST = W'(WDT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // A soft request outranks expiry; either one leaves RUN, so clear on the way out.
  assign expire_o = run_i && !kick_i && (cnt_q == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i || kick_i || soft_i || expire_o) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Matrak SoC reset sequencer: stretches rst_i and releases NUM_CH channels in staggered order.
// Optional watchdog-forced re-reset is enabled by defining RST_WDT_EN.
module reset_sequencer
  import matrak_rst_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int WDT_CYCLES  = DEF_WDT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              soft_rst_req_i,
  input  logic              wdt_kick_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              ready_o,
  output logic              soft_rst_ack_o,
  output logic              wdt_fired_o
);

  localparam int CW = $clog2(HOLD_CYCLES + NUM_CH * GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t            state_q, state_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt, cnt_inc;
  logic [NUM_CH-1:0] rst_q, rst_nxt;
  logic              ready_q, ready_nxt;
  logic              ack_q, ack_nxt;
  logic              wdt_expire;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every variable driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    rst_nxt   = rst_q;
    ready_nxt = ready_q;
    ack_nxt   = 1'b0;

    unique case (state_q)
      ST_ASSERT, ST_RELEASE: begin
        cnt_nxt = cnt_inc;
        // Released channels stay released: only clear bits, never set them.
        for (int i = 0; i < NUM_CH; i++) begin
          if (int'(cnt_inc) >= release_edge(HOLD_CYCLES, GAP_CYCLES, i)) begin
            rst_nxt[i] = 1'b0;
          end
        end
        if (state_q == ST_ASSERT) begin
          if (int'(cnt_inc) >= HOLD_CYCLES) begin
            state_nxt = ST_RELEASE;
          end
        end else if (rst_q == '0) begin
          ready_nxt = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (soft_rst_req_i || wdt_expire) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          ack_nxt   = soft_rst_req_i;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
        rst_nxt   = '1;
        ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      rst_q   <= rst_nxt;
      ready_q <= ready_nxt;
      ack_q   <= ack_nxt;
    end
  end

`ifdef RST_WDT_EN
  logic fired_q;

  rst_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (state_q == ST_RUN),
    .kick_i  (wdt_kick_i),
    .soft_i  (soft_rst_req_i),
    .expire_o(wdt_expire)
  );

  // Sticky until board reset; a simultaneous soft request takes the credit instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fired_q <= 1'b0;
    end else if (state_q == ST_RUN && !soft_rst_req_i && wdt_expire) begin
      fired_q <= 1'b1;
    end
  end

  assign wdt_fired_o = fired_q;
`else
  logic unused_kick;

  assign unused_kick = wdt_kick_i;
  assign wdt_expire  = 1'b0;
  assign wdt_fired_o = 1'b0;
`endif

  assign rst_o          = rst_q;
  assign ready_o        = ready_q;
  assign soft_rst_ack_o = ack_q;

endmodule
